// File: rtl/sha2_compress_iter.sv
// Iterative SHA-2 compression engine: one round per clock over a sliding 16-word
// message window, then a feed-forward add of the latched chaining state.
module sha2_compress_iter #(
   parameter int WORD = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [16*WORD-1:0]   i_blk_in,
   input  logic [8*WORD-1:0]    i_h_in,
   output logic [6:0]           o_k_idx,
   input  logic [WORD-1:0]      i_k_word,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [8*WORD-1:0]    o_h_out,
   output logic                 o_busy
);

   localparam int ROUNDS = (WORD == 64) ? 80 : 64;

   if (WORD != 64 && WORD != 32) begin : g_badWord
      $error("sha2_compress_iter: WORD must be 64 or 32");
   end

   // Rotate/shift amounts of the big and small sigma functions for each family
   localparam int BS0A = (WORD == 64) ? 28 : 2;
   localparam int BS0B = (WORD == 64) ? 34 : 13;
   localparam int BS0C = (WORD == 64) ? 39 : 22;
   localparam int BS1A = (WORD == 64) ? 14 : 6;
   localparam int BS1B = (WORD == 64) ? 18 : 11;
   localparam int BS1C = (WORD == 64) ? 41 : 25;
   localparam int SS0A = (WORD == 64) ? 1  : 7;
   localparam int SS0B = (WORD == 64) ? 8  : 18;
   localparam int SS0S = (WORD == 64) ? 7  : 3;
   localparam int SS1A = (WORD == 64) ? 19 : 17;
   localparam int SS1B = (WORD == 64) ? 61 : 19;
   localparam int SS1S = (WORD == 64) ? 6  : 10;

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [WORD-1:0]   r_work [8];
   logic [WORD-1:0]   r_hIn  [8];
   logic [WORD-1:0]   r_win  [16];
   logic [6:0]        r_t;
   logic [8*WORD-1:0] r_hOut;

   logic [WORD-1:0]   w_sum0, w_sum1, w_ch, w_maj, w_t1, w_t2;
   logic [WORD-1:0]   w_sig0, w_sig1, w_wNew;

   function automatic logic [WORD-1:0] f_ror(input logic [WORD-1:0] x, input int n);
      return (x >> n) | (x << (WORD - n));
   endfunction

   // Round function and next schedule word; r_win[0] is W[t]
   always_comb begin
      w_sum0 = f_ror(r_work[0], BS0A) ^ f_ror(r_work[0], BS0B) ^ f_ror(r_work[0], BS0C);
      w_sum1 = f_ror(r_work[4], BS1A) ^ f_ror(r_work[4], BS1B) ^ f_ror(r_work[4], BS1C);
      w_ch   = (r_work[4] & r_work[5]) ^ (~r_work[4] & r_work[6]);
      w_maj  = (r_work[0] & r_work[1]) ^ (r_work[0] & r_work[2]) ^ (r_work[1] & r_work[2]);
      w_t1   = r_work[7] + w_sum1 + w_ch + i_k_word + r_win[0];
      w_t2   = w_sum0 + w_maj;
      w_sig0 = f_ror(r_win[1], SS0A) ^ f_ror(r_win[1], SS0B) ^ (r_win[1] >> SS0S);
      w_sig1 = f_ror(r_win[14], SS1A) ^ f_ror(r_win[14], SS1B) ^ (r_win[14] >> SS1S);
      w_wNew = w_sig1 + r_win[9] + w_sig0 + r_win[0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b0;
      o_k_idx     = 7'd0;
      case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) w_nextState = S_ROUND;
         end
         S_ROUND: begin
            o_busy  = 1'b1;
            o_k_idx = r_t;
            if (r_t == 7'(ROUNDS - 1)) w_nextState = S_FINAL;
         end
         S_FINAL: begin
            o_busy      = 1'b1;
            w_nextState = S_DONE;
         end
         S_DONE: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 8; i++) begin
            r_work[i] <= '0;
            r_hIn[i]  <= '0;
         end
         for (int j = 0; j < 16; j++) r_win[j] <= '0;
         r_t    <= '0;
         r_hOut <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  for (int i = 0; i < 8; i++) begin
                     r_hIn[i]  <= i_h_in[(7-i)*WORD +: WORD];
                     r_work[i] <= i_h_in[(7-i)*WORD +: WORD];
                  end
                  for (int j = 0; j < 16; j++) r_win[j] <= i_blk_in[(15-j)*WORD +: WORD];
                  r_t <= '0;
               end
            end
            S_ROUND: begin
               r_work[0] <= w_t1 + w_t2;
               r_work[1] <= r_work[0];
               r_work[2] <= r_work[1];
               r_work[3] <= r_work[2];
               r_work[4] <= r_work[3] + w_t1;
               r_work[5] <= r_work[4];
               r_work[6] <= r_work[5];
               r_work[7] <= r_work[6];
               for (int j = 0; j < 15; j++) r_win[j] <= r_win[j+1];
               r_win[15] <= w_wNew;
               r_t       <= r_t + 7'd1;
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) r_hOut[(7-i)*WORD +: WORD] <= r_hIn[i] + r_work[i];
            end
            default: ;
         endcase
      end
   end

   assign o_h_out = r_hOut;

endmodule

// File: tb/tb_sha2_compress_iter.sv
// Bench for sha2_compress_iter: a SHA-512 and a SHA-256 instance checked against a
// full-schedule SHA-2 model, with published digests pinning the model.
module tb_sha2_compress_iter;

   localparam logic [63:0] K64 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   localparam logic [511:0] IV512 = 512'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1510e527fade682d19b05688c2b3e6c1f1f83d9abfb41bd6b5be0cd19137e2179;
   localparam logic [511:0] IV256 = {256'b0, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19};
   localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'b0, 64'h18};
   localparam logic [1023:0] ABC256 = {512'b0, 32'h61626380, 448'b0, 32'h18};
   localparam logic [511:0] DIG512 = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
   localparam logic [511:0] DIG256 = {256'b0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
   localparam logic [511:0] DIG896 = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;

   logic clk = 1'b0;
   logic rstN;
   longint cycle = 0;
   int nChecks = 0;
   int nPass = 0;

   logic inValid64, inReady64, outValid64, outReady64, busy64;
   logic [1023:0] blk64;
   logic [511:0] h64, hOut64;
   logic [6:0] kIdx64;
   logic [63:0] kWord64;

   logic inValid32, inReady32, outValid32, outReady32, busy32;
   logic [511:0] blk32;
   logic [255:0] h32, hOut32;
   logic [6:0] kIdx32;
   logic [31:0] kWord32;
   logic [63:0] kRaw32;

   bit pending [2];
   longint accE [2];
   logic [511:0] expH [2];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   assign kWord64 = (kIdx64 < 7'd80) ? K64[kIdx64] : 64'd0;
   assign kRaw32  = (kIdx32 < 7'd80) ? K64[kIdx32] : 64'd0;
   assign kWord32 = kRaw32[63:32];

   sha2_compress_iter #(.WORD(64)) dut64 (
      .i_clk(clk), .i_rst_n(rstN), .i_in_valid(inValid64), .o_in_ready(inReady64),
      .i_blk_in(blk64), .i_h_in(h64), .o_k_idx(kIdx64), .i_k_word(kWord64),
      .o_out_valid(outValid64), .i_out_ready(outReady64), .o_h_out(hOut64), .o_busy(busy64));

   sha2_compress_iter #(.WORD(32)) dut32 (
      .i_clk(clk), .i_rst_n(rstN), .i_in_valid(inValid32), .o_in_ready(inReady32),
      .i_blk_in(blk32), .i_h_in(h32), .o_k_idx(kIdx32), .i_k_word(kWord32),
      .o_out_valid(outValid32), .i_out_ready(outReady32), .o_h_out(hOut32), .o_busy(busy32));

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [63:0] msk(input bit is64, input logic [63:0] x);
      return is64 ? x : {32'b0, x[31:0]};
   endfunction

   function automatic logic [63:0] rotr(input bit is64, input logic [63:0] x, input int n);
      int wd;
      wd = is64 ? 64 : 32;
      return msk(is64, (x >> n) | (x << (wd - n)));
   endfunction

   // Textbook compression: expand the whole schedule up front, then run the rounds
   function automatic logic [511:0] modelCompress(input bit is64, input logic [511:0] hIn, input logic [1023:0] blk);
      logic [63:0] w [80];
      logic [63:0] v [8];
      logic [63:0] hv [8];
      logic [63:0] t1, t2, s0, s1, ch, mj, k;
      logic [511:0] res;
      int nr;
      nr = is64 ? 80 : 64;
      res = '0;
      for (int i = 0; i < 8; i++) hv[i] = is64 ? hIn[511-64*i -: 64] : {32'b0, hIn[255-32*i -: 32]};
      for (int i = 0; i < 16; i++) w[i] = is64 ? blk[1023-64*i -: 64] : {32'b0, blk[511-32*i -: 32]};
      for (int i = 16; i < nr; i++) begin
         s0 = is64 ? (rotr(1, w[i-15], 1) ^ rotr(1, w[i-15], 8) ^ (w[i-15] >> 7))
                   : (rotr(0, w[i-15], 7) ^ rotr(0, w[i-15], 18) ^ (w[i-15] >> 3));
         s1 = is64 ? (rotr(1, w[i-2], 19) ^ rotr(1, w[i-2], 61) ^ (w[i-2] >> 6))
                   : (rotr(0, w[i-2], 17) ^ rotr(0, w[i-2], 19) ^ (w[i-2] >> 10));
         w[i] = msk(is64, s1 + w[i-7] + s0 + w[i-16]);
      end
      for (int i = 0; i < 8; i++) v[i] = hv[i];
      for (int t = 0; t < nr; t++) begin
         s1 = is64 ? (rotr(1, v[4], 14) ^ rotr(1, v[4], 18) ^ rotr(1, v[4], 41))
                   : (rotr(0, v[4], 6) ^ rotr(0, v[4], 11) ^ rotr(0, v[4], 25));
         s0 = is64 ? (rotr(1, v[0], 28) ^ rotr(1, v[0], 34) ^ rotr(1, v[0], 39))
                   : (rotr(0, v[0], 2) ^ rotr(0, v[0], 13) ^ rotr(0, v[0], 22));
         ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
         mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
         k = K64[t];
         if (!is64) k = k >> 32;
         t1 = msk(is64, v[7] + s1 + ch + k + w[t]);
         t2 = msk(is64, s0 + mj);
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = msk(is64, v[3] + t1);
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = msk(is64, t1 + t2);
      end
      for (int i = 0; i < 8; i++) begin
         if (is64) res[511-64*i -: 64] = hv[i] + v[i];
         else      res[255-32*i -: 32] = hv[i][31:0] + v[i][31:0];
      end
      return res;
   endfunction

   // Per-cycle expectation from the block's age since its accept edge
   task automatic modelStep(input bit is64, input logic inReady, input logic outValid, input logic busy,
                            input logic [6:0] kIdx, input logic [511:0] hOut, input logic inValid,
                            input logic outReady, input logic [511:0] hIn, input logic [1023:0] blk);
      string sfx;
      longint age;
      longint nr;
      logic expOV;
      logic [6:0] expK;
      int d;
      d = is64 ? 1 : 0;
      sfx = is64 ? "64" : "32";
      nr = is64 ? 80 : 64;
      if (!rstN) begin
         pending[d] = 1'b0;
         checkOutput({"rstInReady", sfx}, 512'(inReady), 512'd1);
         checkOutput({"rstOutValid", sfx}, 512'(outValid), 512'd0);
         checkOutput({"rstBusy", sfx}, 512'(busy), 512'd0);
         checkOutput({"rstKIdx", sfx}, 512'(kIdx), 512'd0);
         checkOutput({"rstHOut", sfx}, hOut, 512'd0);
      end else begin
         age = cycle - accE[d];
         expOV = pending[d] && (age >= nr + 1);
         expK = (pending[d] && age < nr) ? 7'(age) : 7'd0;
         checkOutput({"inReady", sfx}, 512'(inReady), 512'(!pending[d]));
         checkOutput({"busy", sfx}, 512'(busy), 512'(pending[d] && age <= nr));
         checkOutput({"kIdx", sfx}, 512'(kIdx), 512'(expK));
         checkOutput({"outValid", sfx}, 512'(outValid), 512'(expOV));
         if (expOV) checkOutput({"hOut", sfx}, hOut, expH[d]);
         if (!pending[d] && inValid) begin
            pending[d] = 1'b1;
            accE[d] = cycle + 1;
            expH[d] = modelCompress(is64, hIn, blk);
         end else if (expOV && outReady) begin
            pending[d] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      modelStep(1'b1, inReady64, outValid64, busy64, kIdx64, hOut64, inValid64, outReady64, h64, blk64);
      modelStep(1'b0, inReady32, outValid32, busy32, kIdx32, {256'b0, hOut32}, inValid32, outReady32,
                {256'b0, h32}, {512'b0, blk32});
   end

   task automatic applyStimulus(input bit is64, input logic [511:0] h, input logic [1023:0] blk,
                                output longint acceptEdge);
      bit got;
      got = 1'b0;
      acceptEdge = 0;
      @(posedge clk); #1;
      if (is64) begin h64 = h; blk64 = blk; inValid64 = 1'b1; end
      else begin h32 = h[255:0]; blk32 = blk[511:0]; inValid32 = 1'b1; end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (is64 ? inReady64 : inReady32) begin got = 1'b1; break; end
      end
      if (!got) checkOutput("acceptTimeout", 512'd0, 512'd1);
      acceptEdge = cycle + 1;
      @(posedge clk); #1;
      if (is64) inValid64 = 1'b0;
      else inValid32 = 1'b0;
   endtask

   task automatic waitOutput(input bit is64, input int budget, output longint seenCycle);
      bit got;
      got = 1'b0;
      seenCycle = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (is64 ? outValid64 : outValid32) begin got = 1'b1; seenCycle = cycle; break; end
      end
      if (!got) checkOutput("outValidTimeout", 512'd0, 512'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint e, f;
      longint acc [8];
      int nAcc;
      logic [511:0] mid;
      logic [1023:0] blk1, blk2;
      string msg;

      rstN = 1'b0;
      inValid64 = 1'b0; outReady64 = 1'b1; blk64 = '0; h64 = '0;
      inValid32 = 1'b0; outReady32 = 1'b1; blk32 = '0; h32 = '0;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;

      checkOutput("modelAbc512", modelCompress(1'b1, IV512, ABC512), DIG512);
      checkOutput("modelAbc256", modelCompress(1'b0, IV256, ABC256), DIG256);

      $display("[TB] T1 SHA-512 abc");
      applyStimulus(1'b1, IV512, ABC512, e);
      waitOutput(1'b1, 200, f);
      checkOutput("latency512", 512'(f - e), 512'd81);
      checkOutput("digest512", hOut64, DIG512);
      repeat (2) @(posedge clk);

      $display("[TB] T2 SHA-256 abc");
      applyStimulus(1'b0, IV256, ABC256, e);
      waitOutput(1'b0, 200, f);
      checkOutput("latency256", 512'(f - e), 512'd65);
      checkOutput("digest256", {256'b0, hOut32}, DIG256);
      repeat (2) @(posedge clk);

      $display("[TB] T3 output backpressure");
      #1 outReady64 = 1'b0;
      applyStimulus(1'b1, IV512, ABC512, e);
      waitOutput(1'b1, 200, f);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         inValid64 = ~inValid64;
         blk64 = blk64 ^ {16{64'h0123456789abcdef}};
      end
      @(posedge clk); #1;
      inValid64 = 1'b0;
      outReady64 = 1'b1;
      @(posedge clk); #1;
      outReady64 = 1'b0;
      repeat (3) @(posedge clk);
      #1 outReady64 = 1'b1;

      $display("[TB] T4 reset mid-round");
      applyStimulus(1'b1, IV512, ABC512, e);
      repeat (39) @(posedge clk);
      @(negedge clk);
      #2 rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      repeat (100) @(posedge clk);
      applyStimulus(1'b1, IV512, ABC512, e);
      waitOutput(1'b1, 200, f);
      checkOutput("digestAfterAbort", hOut64, DIG512);
      repeat (2) @(posedge clk);

      $display("[TB] T5 two-block SHA-512");
      msg = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
      blk1 = '0;
      for (int i = 0; i < 112; i++) blk1[1023-8*i -: 8] = msg[i];
      blk1[127:120] = 8'h80;
      blk2 = 1024'd896;
      applyStimulus(1'b1, IV512, blk1, e);
      waitOutput(1'b1, 200, f);
      mid = hOut64;
      applyStimulus(1'b1, mid, blk2, e);
      waitOutput(1'b1, 200, f);
      checkOutput("digest896", hOut64, DIG896);
      checkOutput("modelDigest896", modelCompress(1'b1, modelCompress(1'b1, IV512, blk1), blk2), DIG896);
      repeat (2) @(posedge clk);

      $display("[TB] T6 back-to-back throughput");
      nAcc = 0;
      @(posedge clk); #1;
      h32 = IV256[255:0];
      blk32 = ABC256[511:0];
      inValid32 = 1'b1;
      for (int i = 0; i < 203; i++) begin
         @(negedge clk);
         if (inReady32 && nAcc < 8) begin acc[nAcc] = cycle + 1; nAcc++; end
      end
      @(posedge clk); #1 inValid32 = 1'b0;
      checkOutput("acceptCount", 512'(nAcc), 512'd4);
      for (int i = 0; i < 3; i++) checkOutput("acceptSpacing", 512'(acc[i+1] - acc[i]), 512'd67);
      repeat (80) @(posedge clk);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
